// File: rtl/div32_seq_if.sv
// Request/response bundle for the sequential 32-bit divider.
// The master drives the request and operands; the slave returns the results and status.
interface div32_seq_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic             i_signed;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;
    logic             o_busy;
    logic             o_done;
    logic             o_divz;

    modport master (
        output i_start, i_signed, i_a, i_b,
        input  o_hi, o_lo, o_busy, o_done, o_divz
    );

    modport slave (
        input  i_start, i_signed, i_a, i_b,
        output o_hi, o_lo, o_busy, o_done, o_divz
    );
endinterface

// File: rtl/div32_seq.sv
// Sequential restoring divider, signed (DIV) or unsigned (DIVU).
// One quotient bit per clock. Signed operands are divided as magnitudes and the
// signs are applied on the way out. HI = remainder, LO = quotient.
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    div32_seq_if.slave  io_bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [5:0]       r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_a_orig;
    logic             r_signed;
    logic             r_qneg;
    logic             r_rneg;
    logic             r_zero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_divz;

    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    // Trial subtraction of one restoring step, plus operand magnitudes for capture.
    always_comb begin
        w_rem_shift = {r_rem, r_quo[WIDTH-1]};
        w_trial     = w_rem_shift - {1'b0, r_div};
        w_abs_a     = io_bus.i_a[WIDTH-1] ? -io_bus.i_a : io_bus.i_a;
        w_abs_b     = io_bus.i_b[WIDTH-1] ? -io_bus.i_b : io_bus.i_b;
    end

    // Control FSM and datapath: capture, iterate, sign-fix, report.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 6'd0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_a_orig <= '0;
            r_signed <= 1'b0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_zero   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_divz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.i_start) begin
                        r_a_orig <= io_bus.i_a;
                        r_signed <= io_bus.i_signed;
                        r_rem    <= '0;
                        r_cnt    <= 6'd0;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_divz   <= 1'b0;
                        if (io_bus.i_signed) begin
                            r_quo  <= w_abs_a;
                            r_div  <= w_abs_b;
                            r_qneg <= io_bus.i_a[WIDTH-1] ^ io_bus.i_b[WIDTH-1];
                            r_rneg <= io_bus.i_a[WIDTH-1];
                        end else begin
                            r_quo  <= io_bus.i_a;
                            r_div  <= io_bus.i_b;
                            r_qneg <= 1'b0;
                            r_rneg <= 1'b0;
                        end
                        if (io_bus.i_b == '0) begin
                            r_zero  <= 1'b1;
                            r_state <= S_FIX;
                        end else begin
                            r_zero  <= 1'b0;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                    end else begin
                        r_rem <= w_rem_shift[WIDTH-1:0];
                    end
                    r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_zero) begin
                        r_hi   <= r_a_orig;
                        r_lo   <= '1;
                        r_divz <= 1'b1;
                    end else begin
                        r_lo   <= (r_signed && r_qneg) ? -r_quo : r_quo;
                        r_hi   <= (r_signed && r_rneg) ? -r_rem : r_rem;
                        r_divz <= 1'b0;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.o_hi   = r_hi;
    assign io_bus.o_lo   = r_lo;
    assign io_bus.o_busy = r_busy;
    assign io_bus.o_done = r_done;
    assign io_bus.o_divz = r_divz;
endmodule

// File: tb/tb_div32_seq.sv
// Randomized scoreboard bench for div32_seq: stimulus pushes reference results,
// an independent monitor pops and compares on every DONE pulse.
module tb_div32_seq;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        divz;
        int          doneCyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   passCount = 0;
    int   checkCount = 0;
    exp_t sb[$];
    bit   prevDone = 1'b0;

    div32_seq_if bus();

    div32_seq #(.WIDTH(32)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Rising-edge counter used to check result latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference result using plain integer division at 64-bit precision.
    function automatic exp_t refModel(input bit sgn, input logic [31:0] a,
                                      input logic [31:0] b, input int doneCyc);
        exp_t   e;
        longint sa;
        longint sbv;
        longint q;
        longint r;
        e.doneCyc = doneCyc;
        if (b == 32'd0) begin
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
            e.divz = 1'b1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sbv = longint'($signed(b));
            q = sa / sbv;
            r = sa % sbv;
            e.lo = q[31:0];
            e.hi = r[31:0];
            e.divz = 1'b0;
        end else begin
            e.lo = a / b;
            e.hi = a % b;
            e.divz = 1'b0;
        end
        return e;
    endfunction

    // Single comparison; counts and reports.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Wait (bounded) at negedges until the divider is idle.
    task automatic waitIdle(output bit ok);
        int n = 0;
        while ((bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 200);
        if (!ok) checkOutput("idle_timeout", 32'd1, 32'd0);
    endtask

    // Issue one operation from a negedge; operands are scrambled afterwards.
    task automatic applyStimulus(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        waitIdle(ok);
        if (!ok) return;
        bus.i_start  = 1'b1;
        bus.i_signed = sgn;
        bus.i_a      = a;
        bus.i_b      = b;
        sb.push_back(refModel(sgn, a, b, cyc + ((b == 32'd0) ? 2 : 34)));
        @(negedge clk);
        bus.i_start  = 1'b0;
        bus.i_a      = $urandom;
        bus.i_b      = $urandom;
        bus.i_signed = 1'($urandom);
        checkOutput("busy_after_accept", {31'd0, bus.o_busy}, 32'd1);
    endtask

    // START held high with changing operands through the operation and the DONE cycle.
    task automatic holdStartTest();
        bit ok;
        int n = 0;
        waitIdle(ok);
        if (!ok) return;
        bus.i_start  = 1'b1;
        bus.i_signed = 1'b0;
        bus.i_a      = 32'd1000;
        bus.i_b      = 32'd7;
        sb.push_back(refModel(1'b0, 32'd1000, 32'd7, cyc + 34));
        @(negedge clk);
        while (bus.o_done !== 1'b1 && n < 100) begin
            bus.i_a      = $urandom;
            bus.i_b      = $urandom;
            bus.i_signed = 1'($urandom);
            @(negedge clk);
            n++;
        end
        if (n >= 100) checkOutput("hold_done_timeout", 32'd1, 32'd0);
        bus.i_a = 32'd55;
        bus.i_b = 32'd5;
        @(negedge clk);
        checkOutput("start_in_done_ignored", {31'd0, bus.o_busy}, 32'd0);
        bus.i_start = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    // Reset at edge n+10 of an operation, then a fresh 100/7.
    task automatic resetMidOpTest();
        bit ok;
        waitIdle(ok);
        if (!ok) return;
        bus.i_start  = 1'b1;
        bus.i_signed = 1'b0;
        bus.i_a      = 32'd123456;
        bus.i_b      = 32'd17;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_hi",   bus.o_hi, 32'd0);
        checkOutput("rst_lo",   bus.o_lo, 32'd0);
        checkOutput("rst_busy", {31'd0, bus.o_busy}, 32'd0);
        checkOutput("rst_done", {31'd0, bus.o_done}, 32'd0);
        checkOutput("rst_divz", {31'd0, bus.o_divz}, 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 32'd100, 32'd7);
    endtask

    // Monitor: compare every DONE pulse against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prevDone = 1'b0;
        end else begin
            if (bus.o_done === 1'b1) begin
                if (prevDone) checkOutput("done_one_cycle", 32'd1, 32'd0);
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("lo", bus.o_lo, e.lo);
                    checkOutput("hi", bus.o_hi, e.hi);
                    checkOutput("divz", {31'd0, bus.o_divz}, {31'd0, e.divz});
                    checkOutput("latency", 32'(cyc), 32'(e.doneCyc));
                    checkOutput("busy_at_done", {31'd0, bus.o_busy}, 32'd0);
                end
            end
            prevDone = (bus.o_done === 1'b1);
        end
    end

    // Main sequence: reset, directed cases, hold/reset scenarios, random traffic.
    initial begin
        int drain = 0;
        bus.i_start  = 1'b0;
        bus.i_signed = 1'b0;
        bus.i_a      = 32'd0;
        bus.i_b      = 32'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_hi",   bus.o_hi, 32'd0);
        checkOutput("reset_lo",   bus.o_lo, 32'd0);
        checkOutput("reset_busy", {31'd0, bus.o_busy}, 32'd0);
        checkOutput("reset_done", {31'd0, bus.o_done}, 32'd0);
        checkOutput("reset_divz", {31'd0, bus.o_divz}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(1'b0, 32'd9, 32'd8);
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h10);
        applyStimulus(1'b0, 32'h0000_1234, 32'd0);
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 32'h8000_0001, 32'd0);
        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE);
        applyStimulus(1'b0, 32'd5, 32'hFFFF_FFFF);

        holdStartTest();
        resetMidOpTest();

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 16));
                2: b = a >> $urandom_range(0, 8);
                3: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            applyStimulus(1'($urandom), a, b);
        end

        while (sb.size() != 0 && drain < 200) begin
            @(negedge clk);
            drain++;
        end
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/div32_seq.md
DIV32_SEQ -- requirements
Module: div32_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 Port: CLK  input  1  single clock; all state changes on rising edge.
REQ-003 Port: RST  input  1  reset; synchronous, active-high.
REQ-004 Port: START  input  1  request; sampled only when BUSY=0.
REQ-005 Port: SIGNED  input  1  1 = two's-complement divide (DIV); 0 = unsigned (DIVU).
REQ-006 Port: A  input  32  dividend.
REQ-007 Port: B  input  32  divisor.
REQ-008 Port: HI  output  32  remainder, registered.
REQ-009 Port: LO  output  32  quotient, registered.
REQ-010 Port: BUSY  output  1  high from the accepting edge until DONE is asserted.
REQ-011 Port: DONE  output  1  one-cycle pulse; HI/LO valid.
REQ-012 Port: DIVZ  output  1  registered with DONE; high when the completed operation had B=0.

Function
REQ-013 States SHALL be IDLE, RUN, FIX and DONE, with one-hot or encoded state.
REQ-014 IDLE: START=1 at edge n SHALL capture A, B and SIGNED, set BUSY=1, and clear DONE and DIVZ.
REQ-015 Operand capture: if SIGNED=1, the magnitudes of A and B SHALL be stored along with the quotient sign (A[31]^B[31]) and the remainder sign (A[31]); if SIGNED=0, A and B SHALL be stored as given.
REQ-016 B=0 at capture SHALL go directly to FIX with the divide-by-zero flag set, bypassing RUN.
REQ-017 B≠0: RUN SHALL perform one restoring shift-subtract step per edge, for exactly 32 edges (n+1..n+32), using a 6-bit iteration counter.
REQ-018 Each RUN step: {rem,quo} SHALL shift left by 1; the trial value rem-divisor SHALL be computed as a 33-bit result; if it is non-negative, rem SHALL take the trial value and the quotient LSB SHALL be set to 1, otherwise rem SHALL be kept and the quotient LSB SHALL be 0.
REQ-019 FIX (edge n+33): the block SHALL write LO to the quotient, negated if SIGNED and the quotient sign is set; it SHALL write HI to the remainder, negated if SIGNED and the remainder sign is set; it SHALL set DONE=1 and BUSY=0, and go to DONE.
REQ-020 Divide by zero (FIX at edge n+1): the block SHALL set HI=A (original, unmodified), LO=32'hFFFFFFFF, DIVZ=1 and DONE=1, regardless of SIGNED.
REQ-021 DONE state: at the next edge, DONE SHALL return to 0 and the state SHALL go to IDLE; a START in this cycle SHALL be ignored.
REQ-022 Latency: DONE SHALL be high in the cycle after edge n+33 (normal) or n+1 (B=0), for exactly one cycle.
REQ-023 HI, LO and DIVZ SHALL hold their values until the next FIX write or reset.
REQ-024 START while BUSY=1 SHALL be ignored, and operands SHALL not be resampled during the operation.
REQ-025 Signed overflow: 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0, with no error flag.
REQ-026 Signed results SHALL satisfy A = LO*B + HI, with the quotient truncated toward zero and the remainder carrying the sign of A.

Reset
REQ-027 When RST=1 at an edge, the block SHALL take state IDLE and set HI=0, LO=0, BUSY=0, DONE=0, DIVZ=0, and clear the counter; RST SHALL take priority over START.
REQ-028 Reset mid-operation (RUN or FIX) SHALL abort the operation with no DONE pulse; the block SHALL accept a new START on the first edge with RST=0.

Verification
REQ-029 Unsigned A=9, B=8, START at edge n -> BUSY=1 from n, DONE pulse after n+33, LO=1, HI=1, DIVZ=0.
REQ-030 SIGNED=1, A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); unsigned 0xFFFFFFFF/0x10 -> LO=0x0FFFFFFF, HI=0xF.
REQ-031 A=0x00001234, B=0 -> DONE after edge n+1, HI=0x00001234, LO=0xFFFFFFFF, DIVZ=1.
REQ-032 SIGNED=1, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0, DIVZ=0.
REQ-033 START held high continuously with new operands mid-operation -> only the first operands are used, one DONE per accepted operation, and START during the DONE cycle is ignored.
REQ-034 RST asserted at edge n+10 of an operation -> all outputs 0 on the next cycle, no DONE; a following 100/7 operation returns LO=14, HI=2.
